difftest_inject_irqc: RTL and testbench
=======================================

DIFFTEST_INJECT_IRQC -- requirements
Module: difftest_inject_irqc

Interface
REQ-001 SHALL have parameter CONFIG_NUM_IRQ, default 32: number of IRQ lines driven (1..32).
REQ-002 SHALL have parameter CONFIG_INJ_TIMEOUT, default 16: maximum WAIT cycles before a timeout (>=1).
REQ-003 SHALL have parameter CONFIG_INJ_FIFO_DEPTH, default 4: command queue entries (power of 2, >=2).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- inj_valid  in  1  emulator command valid.
- inj_ready  out  1  command accepted this cycle when high with inj_valid.
- inj_irq  in  5  target IRQ number.
- inj_set  in  1  1=assert line, 0=deassert line.
- irq_o  out  CONFIG_NUM_IRQ  level IRQ lines into the DUT IRQ controller.
- irqc_irr  in  CONFIG_NUM_IRQ  DUT IRQ controller pending register, observed for confirmation.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_irq  out  5  IRQ number of the completed command.
- rsp_status  out  2  0=OK, 1=TIMEOUT, 2=BADIRQ.
- busy  out  1  high while a command is queued or in flight.

Function
REQ-005 SHALL push {inj_irq, inj_set} into the FIFO on posedge when inj_valid && inj_ready.
REQ-006 inj_ready SHALL equal !full; a pop in the same cycle SHALL NOT make room for a push while full.
REQ-007 Commands SHALL execute strictly in FIFO order, one at a time.
REQ-008 FSM states: IDLE, DRIVE, WAIT, RESP.
REQ-009 IDLE: if the FIFO is non-empty, pop the head, latch cmd_irq/cmd_set, go to DRIVE; otherwise stay.
REQ-010 DRIVE: if cmd_irq >= CONFIG_NUM_IRQ, leave irq_o unchanged, status=BADIRQ, go to RESP; else set irq_o[cmd_irq]=cmd_set, clear the wait counter, go to WAIT.
REQ-011 WAIT: if irqc_irr[cmd_irq]==cmd_set, status=OK, go to RESP.
REQ-012 WAIT: if there is no match and the counter equals CONFIG_INJ_TIMEOUT-1, status=TIMEOUT, go to RESP.
REQ-013 WAIT: otherwise increment the counter and stay; a match SHALL take priority over timeout in the same cycle.
REQ-014 RESP: rsp_valid=1 for exactly one cycle with rsp_irq/rsp_status, then go to IDLE.
REQ-015 rsp_irq/rsp_status SHALL hold their last values while rsp_valid=0.
REQ-016 rsp has no backpressure.
REQ-017 irq_o SHALL retain the driven value after TIMEOUT; only a later command or reset changes it.
REQ-018 Only bit cmd_irq of irq_o SHALL change per command; all other bits hold.
REQ-019 Best-case latency: push at edge E0, pop at E1, irq_o updated at E2, match sampled before E3, rsp_valid high in the cycle after E3.
REQ-020 busy SHALL equal (state!=IDLE) || FIFO non-empty.
REQ-021 The FIFO read/write pointers SHALL wrap modulo CONFIG_INJ_FIFO_DEPTH, with a separate full/empty indication (extra pointer bit).
REQ-022 The wait counter SHALL be $clog2(CONFIG_INJ_TIMEOUT+1) bits and SHALL NOT wrap.

Reset
REQ-023 When rst_n=0 at posedge, the block SHALL set state=IDLE, FIFO empty, irq_o=0, rsp_valid=0, rsp_irq=0, rsp_status=0, counter=0.
REQ-024 Reset mid-operation SHALL discard queued and in-flight commands without emitting a response.
REQ-025 While rst_n=0, inj_ready SHALL read 1 (FIFO empty), and pushes SHALL be ignored.

Verification
REQ-026 SET irq 3, irqc_irr mirrors irq_o with 1-cycle delay -> irq_o[3]=1 after E2; rsp_valid, rsp_irq=3, rsp_status=0 one cycle later than the best case.
REQ-027 SET irq 5, irqc_irr tied 0, TIMEOUT=16 -> exactly 16 WAIT cycles, then rsp_status=1; irq_o[5] stays 1 afterward.
REQ-028 Six back-to-back commands while the FSM is held in WAIT (irr tied 0) -> inj_ready low after 4 accepted; responses in push order; none lost or duplicated.
REQ-029 Command irq=31 with CONFIG_NUM_IRQ=8 -> rsp_status=2, irq_o unchanged, no WAIT state entered.
REQ-030 rst_n low for 1 cycle during WAIT with 2 queued -> next cycle irq_o=0, busy=0, inj_ready=1, no rsp_valid ever for the dropped commands.
REQ-031 CLR irq 2 when irq_o[2]=0 and irqc_irr[2]=0 -> rsp_status=0 on the first WAIT cycle (best-case latency).

Source files
------------

// File: rtl/difftest_inject_irqc.sv
// difftest_inject_irqc
// Queues IRQ set/clear commands from an emulator, drives them one at a time
// onto level IRQ lines feeding the DUT's interrupt controller, then waits for
// the controller's pending register to reflect the change (or times out) and
// reports the outcome with a one-cycle response pulse.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   inj_valid/inj_ready     command handshake; inj_irq = line number,
//                           inj_set = 1 assert / 0 deassert
//   irq_o                   level IRQ lines into the DUT
//   irqc_irr                DUT pending register, used for confirmation
//   rsp_valid               one-cycle completion pulse
//   rsp_irq, rsp_status     completed IRQ number and 0=OK/1=TIMEOUT/2=BADIRQ
//                           (held between pulses)
//   busy                    command queued or in flight
module difftest_inject_irqc #(
  parameter int CONFIG_NUM_IRQ        = 32,
  parameter int CONFIG_INJ_TIMEOUT    = 16,
  parameter int CONFIG_INJ_FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inj_valid,
  output logic                      inj_ready,
  input  logic [4:0]                inj_irq,
  input  logic                      inj_set,
  output logic [CONFIG_NUM_IRQ-1:0] irq_o,
  input  logic [CONFIG_NUM_IRQ-1:0] irqc_irr,
  output logic                      rsp_valid,
  output logic [4:0]                rsp_irq,
  output logic [1:0]                rsp_status,
  output logic                      busy
);

  localparam int AW = $clog2(CONFIG_INJ_FIFO_DEPTH);
  localparam int CW = $clog2(CONFIG_INJ_TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BADIRQ  = 2'd2;

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

  state_t state_reg, state_next;

  // Command queue: {irq, set} per entry; pointers carry one extra bit so
  // full and empty are distinguishable when the low bits coincide.
  logic [5:0]    fifo_mem [CONFIG_INJ_FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          fifo_full, fifo_empty, push, pop;

  logic [4:0]    cmd_irq_reg;
  logic          cmd_set_reg;
  logic [CW-1:0] cnt_reg;
  logic [4:0]    rsp_irq_reg;
  logic [1:0]    rsp_status_reg;
  logic [CONFIG_NUM_IRQ-1:0] irq_reg;

  logic          cmd_bad, irr_match;
  logic          load_status, cnt_clr, cnt_inc;
  logic [1:0]    status_next;
  logic [31:0]   irr_ext;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Full is judged on the registered pointers only, so a pop in the same
  // cycle never opens a slot. During reset the queue is treated as empty.
  assign inj_ready = !fifo_full || !rst_n;
  assign push      = inj_valid && !fifo_full;
  assign pop       = (state_reg == IDLE) && !fifo_empty;

  // Zero-extend so any 5-bit command index selects a defined bit.
  assign irr_ext   = 32'(irqc_irr);
  assign cmd_bad   = int'(cmd_irq_reg) >= CONFIG_NUM_IRQ;
  assign irr_match = (irr_ext[cmd_irq_reg] == cmd_set_reg);

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {inj_irq, inj_set};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cmd_irq_reg    <= '0;
      cmd_set_reg    <= 1'b0;
      cnt_reg        <= '0;
      rsp_irq_reg    <= '0;
      rsp_status_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        cmd_irq_reg <= fifo_mem[rd_ptr_reg[AW-1:0]][5:1];
        cmd_set_reg <= fifo_mem[rd_ptr_reg[AW-1:0]][0];
      end
      if (cnt_clr)      cnt_reg <= '0;
      else if (cnt_inc) cnt_reg <= cnt_reg + 1'b1;
      if (load_status) begin
        rsp_irq_reg    <= cmd_irq_reg;
        rsp_status_reg <= status_next;
      end
    end
  end

  // One flop per line; only the addressed line is written while in DRIVE.
  // An out-of-range index matches no line, leaving all of them untouched.
  generate
    for (genvar gi = 0; gi < CONFIG_NUM_IRQ; gi++) begin : g_irq
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          irq_reg[gi] <= 1'b0;
        end else if (state_reg == DRIVE && cmd_irq_reg == 5'(gi)) begin
          irq_reg[gi] <= cmd_set_reg;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    load_status = 1'b0;
    status_next = ST_OK;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = DRIVE;
      end
      DRIVE: begin
        if (cmd_bad) begin
          status_next = ST_BADIRQ;
          load_status = 1'b1;
          state_next  = RESP;
        end else begin
          cnt_clr    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Confirmation wins over timeout when both happen together.
        if (irr_match) begin
          status_next = ST_OK;
          load_status = 1'b1;
          state_next  = RESP;
        end else if (cnt_reg == CW'(CONFIG_INJ_TIMEOUT - 1)) begin
          status_next = ST_TIMEOUT;
          load_status = 1'b1;
          state_next  = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign irq_o      = irq_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_irq    = rsp_irq_reg;
  assign rsp_status = rsp_status_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_difftest_inject_irqc.sv
// Bench for difftest_inject_irqc (8 IRQ lines, timeout 16, queue depth 4).
// irqc_irr is either a one-cycle-delayed copy of irq_o or tied to zero.
module tb_difftest_inject_irqc;

  localparam int NIRQ = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            inj_valid;
  logic            inj_ready;
  logic [4:0]      inj_irq;
  logic            inj_set;
  logic [NIRQ-1:0] irq_o;
  logic [NIRQ-1:0] irqc_irr;
  logic            rsp_valid;
  logic [4:0]      rsp_irq;
  logic [1:0]      rsp_status;
  logic            busy;

  difftest_inject_irqc #(
    .CONFIG_NUM_IRQ(NIRQ),
    .CONFIG_INJ_TIMEOUT(16),
    .CONFIG_INJ_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inj_valid(inj_valid), .inj_ready(inj_ready),
    .inj_irq(inj_irq), .inj_set(inj_set),
    .irq_o(irq_o), .irqc_irr(irqc_irr),
    .rsp_valid(rsp_valid), .rsp_irq(rsp_irq), .rsp_status(rsp_status),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic            mirror_mode = 1'b0;
  logic [NIRQ-1:0] irr_mirror = '0;
  always @(posedge clk) irr_mirror <= irq_o;
  assign irqc_irr = mirror_mode ? irr_mirror : '0;

  typedef struct {
    logic [4:0] irq;
    logic [1:0] status;
  } exp_t;

  typedef struct {
    bit         mirror;
    logic [4:0] irq;
    logic       set;
    logic [1:0] exp_status;
    int         exp_lat;
  } vec_t;

  exp_t            exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              rsp_count = 0;
  logic [NIRQ-1:0] model_irq = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] status_of(input bit mirror, input logic [4:0] irq, input logic set);
    if (int'(irq) >= NIRQ) return 2'd2;
    if (!mirror && set) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_apply(input logic [4:0] irq, input logic set);
    if (int'(irq) < NIRQ) model_irq[irq[2:0]] = set;
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      exp_t e;
      rsp_count++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got irq %0d status %0d with nothing outstanding", rsp_irq, rsp_status);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_irq", 32'(rsp_irq), 32'(e.irq));
        chk("rsp_status", 32'(rsp_status), 32'(e.status));
        $display("rsp irq=%0d status=%0d (expected irq=%0d status=%0d)", rsp_irq, rsp_status, e.irq, e.status);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   cycles;
    exp_t e;
    @(negedge clk);
    mirror_mode = v.mirror;
    inj_valid   = 1'b1;
    inj_irq     = v.irq;
    inj_set     = v.set;
    chk("ready_before_push", 32'(inj_ready), 32'd1);
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    e.irq = v.irq;
    e.status = v.exp_status;
    exp_q.push_back(e);
    model_apply(v.irq, v.set);
    chk("busy_after_push", 32'(busy), 32'd1);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!rsp_valid && cycles < 60);
    chk("latency", 32'(cycles), 32'(v.exp_lat));
    chk("irq_o", 32'(irq_o), 32'(model_irq));
    @(negedge clk);
    chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
    chk("rsp_status_hold", 32'(rsp_status), 32'(v.exp_status));
    chk("busy_idle", 32'(busy), 32'd0);
    $display("vec irq=%0d set=%0d mirror=%0d latency=%0d irq_o=%0h", v.irq, v.set, v.mirror, cycles, irq_o);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] b_irq[6];
    logic       b_set[6];
    int         idx, guard, stall_at, rc0;
    logic       r;
    exp_t       e;

    vecs[0]  = '{1'b1, 5'd3,  1'b1, 2'd0, 4};
    vecs[1]  = '{1'b0, 5'd5,  1'b1, 2'd1, 18};
    vecs[2]  = '{1'b0, 5'd2,  1'b0, 2'd0, 3};
    vecs[3]  = '{1'b0, 5'd31, 1'b1, 2'd2, 2};
    vecs[4]  = '{1'b1, 5'd7,  1'b1, 2'd0, 4};
    vecs[5]  = '{1'b1, 5'd7,  1'b1, 2'd0, 3};
    vecs[6]  = '{1'b1, 5'd5,  1'b0, 2'd0, 4};
    vecs[7]  = '{1'b0, 5'd8,  1'b1, 2'd2, 2};
    vecs[8]  = '{1'b0, 5'd0,  1'b0, 2'd0, 3};
    vecs[9]  = '{1'b1, 5'd0,  1'b1, 2'd0, 4};
    vecs[10] = '{1'b0, 5'd3,  1'b0, 2'd0, 3};
    vecs[11] = '{1'b0, 5'd6,  1'b1, 2'd1, 18};

    rst_n = 1'b0;
    inj_valid = 1'b0;
    inj_irq = '0;
    inj_set = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_irq_o", 32'(irq_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_irq", 32'(rsp_irq), 32'd0);
    chk("reset_rsp_status", 32'(rsp_status), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(inj_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Burst: hold one command in WAIT, then offer six back-to-back.
    @(negedge clk);
    mirror_mode = 1'b0;
    inj_valid = 1'b1; inj_irq = 5'd1; inj_set = 1'b1;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    e.irq = 5'd1; e.status = 2'd1; exp_q.push_back(e);
    model_apply(5'd1, 1'b1);
    rc0 = rsp_count;
    repeat (3) @(posedge clk);
    b_irq = '{5'd2, 5'd3, 5'd9, 5'd4, 5'd6, 5'd7};
    b_set = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    idx = 0; guard = 0; stall_at = -1;
    while (idx < 6 && guard < 500) begin
      @(negedge clk);
      inj_valid = 1'b1;
      inj_irq = b_irq[idx];
      inj_set = b_set[idx];
      r = inj_ready;
      if (!r && stall_at < 0) stall_at = idx;
      @(posedge clk);
      if (r) begin
        e.irq = b_irq[idx];
        e.status = status_of(1'b0, b_irq[idx], b_set[idx]);
        exp_q.push_back(e);
        model_apply(b_irq[idx], b_set[idx]);
        $display("burst push %0d irq=%0d set=%0d", idx, b_irq[idx], b_set[idx]);
        idx++;
      end
      guard++;
    end
    #1;
    inj_valid = 1'b0;
    chk("burst_all_accepted", 32'(idx), 32'd6);
    chk("burst_stall_after", 32'(stall_at), 32'd4);
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("burst_rsp_count", 32'(rsp_count - rc0), 32'd7);
    chk("burst_irq_o", 32'(irq_o), 32'(model_irq));
    chk("burst_busy", 32'(busy), 32'd0);

    // Reset during WAIT with two commands still queued.
    @(negedge clk);
    inj_valid = 1'b1; inj_irq = 5'd4; inj_set = 1'b1;
    @(posedge clk);
    #1;
    e.irq = 5'd4; e.status = 2'd1; exp_q.push_back(e);
    inj_irq = 5'd5;
    @(posedge clk);
    #1;
    e.irq = 5'd5; exp_q.push_back(e);
    inj_irq = 5'd6;
    @(posedge clk);
    #1;
    e.irq = 5'd6; exp_q.push_back(e);
    inj_valid = 1'b0;
    rc0 = rsp_count;
    @(negedge clk);
    rst_n = 1'b0;
    inj_valid = 1'b1; inj_irq = 5'd1; inj_set = 1'b0;
    #1;
    chk("ready_in_reset", 32'(inj_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    inj_valid = 1'b0;
    exp_q.delete();
    model_irq = '0;
    chk("post_reset_irq_o", 32'(irq_o), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_ready", 32'(inj_ready), 32'd1);
    repeat (60) @(negedge clk);
    chk("dropped_no_rsp", 32'(rsp_count - rc0), 32'd0);
    chk("dropped_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
